mbist_march_ctrl: RTL and testbench
===================================

Name: mbist_march_ctrl

Overview:
- MBIST initiator that drives the single-port memory-under-test interface (write_read, address, wdata) and checks the returned rdata.
- Runs a March C- algorithm over addresses 0..CAPACITY and reports pass/fail, a failure count and first-failure diagnostics.
- Sits between the chip test controller (start/done) and one memory instance.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- CAPACITY, 15, highest address exercised; the test covers 0..CAPACITY and requires CAPACITY >= 1.
- CNT_WIDTH, 8, width of fail_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a test; ignored while busy.
- bg_sel  in  1  data background, sampled at start: 0 selects all-zeros as "0", 1 selects all-ones as "0".
- write_read  out  1  memory command: 1 = write, 0 = read.
- address  out  ADDR_WIDTH  memory address.
- wdata  out  DATA_WIDTH  memory write data.
- rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  test in progress.
- done  out  1  level; held high from test end until the next start.
- fail  out  1  sticky; at least one miscompare occurred in this run.
- fail_count  out  CNT_WIDTH  number of miscompared reads; saturates at all-ones.
- fail_addr  out  ADDR_WIDTH  address of the first miscompare.
- fail_elem  out  3  March element (0..5) of the first miscompare.
- fail_syndrome  out  DATA_WIDTH  rdata XOR expected at the first miscompare.

Behaviour:
- Memory contract:
  - wdata must be presented one cycle before the matching write command on write_read/address.
  - Read data for a read command on the port in cycle c is valid on rdata in cycle c+2.
- Algorithm (D0 = {DATA_WIDTH{bg}}, D1 = ~D0):
  - E0 up: w0
  - E1 up: r0, w1
  - E2 up: r1, w0
  - E3 down: r0, w1
  - E4 down: r1, w0
  - E5 up: r0
  - Multi-op elements perform all ops at one address before advancing. Total ops per run = 10*(CAPACITY+1).
- Sequencer:
  - Issues one internal op per cycle with no idle gaps between elements.
  - The internal op k falls in cycle k, counted from the busy rise.
  - wdata is driven combinationally from the internal op in cycle k.
  - write_read and address are registered copies of the internal op, so they appear on the port in cycle k+1.
- FSM states:
  - IDLE: start goes to RUN and latches bg_sel.
  - RUN: the last op of E5 goes to DRAIN.
  - DRAIN: waits 2 cycles for the last compare, then goes to DONE.
  - DONE: start goes to RUN.
- busy rises the cycle after start is sampled and falls when done rises. done rises 10*(CAPACITY+1)+3 cycles after busy rises.
- When not issuing ops (IDLE, DRAIN, DONE, reset): write_read=0, address=0, wdata=0.
- Compare pipeline:
  - The expected value and element travel 2 stages with each read.
  - In cycle k+3, rdata is compared with the expected value.
  - On mismatch: fail is set and fail_count increments (saturating).
  - On the first mismatch only, fail_addr, fail_elem and fail_syndrome are captured.
- start in DONE clears fail, fail_count, fail_addr, fail_elem, fail_syndrome and done, then restarts.
- start in RUN or DRAIN is ignored.
- Reset value of every output is 0. Reset mid-run aborts immediately: the port returns to read at address 0, no further compares occur, and state is IDLE.
- Address counter wrap:
  - Up-elements stop at CAPACITY.
  - Down-elements start at CAPACITY and stop at 0.
  - The counter never indexes beyond CAPACITY.

Decomposition:
- Shared package mbist_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE),
  - the element index localparams E0..E5,
  - the per-element op table (direction, op count, read/write, data polarity).
- One natural sub-module, mbist_resp_cmp: the 2-stage expected-data/address/element pipeline, the comparator, and the fail logging registers.

Test Plan:
- Fault-free memory, CAPACITY=15, bg_sel=0, start pulse -> busy for 163 cycles, done=1, fail=0, fail_count=0; memory ends holding 8'h00 everywhere.
- Stuck-at-1 on bit 1 of address 5, bg_sel=0 -> fail=1, fail_count=3, fail_addr=5, fail_elem=1, fail_syndrome=8'h02.
- Stuck-at-0 on bit 7 of address 0, bg_sel=0 -> fail_count=2, fail_addr=0, fail_elem=2, fail_syndrome=8'h80.
- Same stuck-at-1 as the second scenario, bg_sel=1 -> fail_count=2, fail_elem=2, fail_addr=5, fail_syndrome=8'h02.
- Protocol timing check on a fault-free run:
  - wdata leads the write command by exactly 1 cycle.
  - First port op is write at address 0 in the cycle after busy rises.
  - Address sequence in E3 is 15,15,14,14,...,0,0.
- Mid-run behaviour:
  - rst_n low for 1 cycle in E2 -> all outputs 0, state IDLE.
  - start during RUN has no effect.
  - A new start after done clears the fail registers and repeats the run.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types for the March C- MBIST controller: FSM states, element indices
// and the per-element operation table.
package mbist_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;

  // Bit [n] of rd/pol describes op n of the element; pol=1 selects D1.
  typedef struct packed {
    logic       down;
    logic       two_ops;
    logic [1:0] rd;
    logic [1:0] pol;
  } elem_op_t;

  function automatic elem_op_t elem_op(input logic [2:0] e);
    case (e)
      E0:      elem_op = '{down: 1'b0, two_ops: 1'b0, rd: 2'b00, pol: 2'b00};
      E1:      elem_op = '{down: 1'b0, two_ops: 1'b1, rd: 2'b01, pol: 2'b10};
      E2:      elem_op = '{down: 1'b0, two_ops: 1'b1, rd: 2'b01, pol: 2'b01};
      E3:      elem_op = '{down: 1'b1, two_ops: 1'b1, rd: 2'b01, pol: 2'b10};
      E4:      elem_op = '{down: 1'b1, two_ops: 1'b1, rd: 2'b01, pol: 2'b01};
      E5:      elem_op = '{down: 1'b0, two_ops: 1'b0, rd: 2'b01, pol: 2'b00};
      default: elem_op = '{down: 1'b0, two_ops: 1'b0, rd: 2'b00, pol: 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/mbist_resp_cmp.sv
// Read-response checker: carries expected data/address/element alongside each
// read until its data returns, compares, and logs failures.
module mbist_resp_cmp
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  rd_vld_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            elem_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  fail_o,
  output logic [CNT_WIDTH-1:0]  fail_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [DATA_WIDTH-1:0] fail_syndrome_o
);

  logic [1:0]                 vld_pipe_q;
  logic [1:0][ADDR_WIDTH-1:0] addr_pipe_q;
  logic [1:0][2:0]            elem_pipe_q;
  logic [1:0][DATA_WIDTH-1:0] exp_pipe_q;

  logic                  fail_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] faddr_q;
  logic [2:0]            felem_q;
  logic [DATA_WIDTH-1:0] fsyn_q;

  logic [DATA_WIDTH-1:0] syn;
  logic                  miss;

  assign syn  = rdata_i ^ exp_pipe_q[1];
  assign miss = vld_pipe_q[1] && (syn != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      addr_pipe_q <= '0;
      elem_pipe_q <= '0;
      exp_pipe_q  <= '0;
    end else begin
      vld_pipe_q  <= {vld_pipe_q[0], rd_vld_i};
      addr_pipe_q <= {addr_pipe_q[0], addr_i};
      elem_pipe_q <= {elem_pipe_q[0], elem_i};
      exp_pipe_q  <= {exp_pipe_q[0], exp_i};
    end
  end

  // Diagnostics freeze on the first miscompare; only the count keeps moving.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      fail_q  <= 1'b0;
      cnt_q   <= '0;
      faddr_q <= '0;
      felem_q <= '0;
      fsyn_q  <= '0;
    end else if (miss) begin
      fail_q <= 1'b1;
      if (~&cnt_q) cnt_q <= cnt_q + 1'b1;
      if (!fail_q) begin
        faddr_q <= addr_pipe_q[1];
        felem_q <= elem_pipe_q[1];
        fsyn_q  <= syn;
      end
    end
  end

  assign fail_o          = fail_q;
  assign fail_count_o    = cnt_q;
  assign fail_addr_o     = faddr_q;
  assign fail_elem_o     = felem_q;
  assign fail_syndrome_o = fsyn_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST initiator: sequences one memory op per cycle over 0..CAPACITY
// and hands reads to the response checker.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bg_sel,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syndrome
);

  localparam logic [ADDR_WIDTH-1:0] CAP_A = ADDR_WIDTH'(CAPACITY);

  state_e                state_q;
  logic [2:0]            elem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  op_q;
  logic                  bg_q;
  logic [1:0]            drain_q;
  logic                  busy_q, done_q;
  logic                  wr_q, rd_vld_q;
  logic [ADDR_WIDTH-1:0] port_addr_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [2:0]            elem_p_q;

  elem_op_t              eop, nxt_op;
  logic                  run, cur_rd, last_op, elem_end, accept;
  logic [DATA_WIDTH-1:0] d0, cur_data;

  assign eop      = elem_op(elem_q);
  assign nxt_op   = elem_op(elem_q + 3'd1);
  assign run      = (state_q == S_RUN);
  assign cur_rd   = eop.rd[op_q];
  assign d0       = {DATA_WIDTH{bg_q}};
  assign cur_data = eop.pol[op_q] ? ~d0 : d0;
  assign last_op  = eop.two_ops ? op_q : 1'b1;
  assign elem_end = last_op && (eop.down ? (addr_q == '0) : (addr_q == CAP_A));
  assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);

  // Write data leads the registered command by one cycle.
  assign wdata = (run && !cur_rd) ? cur_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= E0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      bg_q        <= 1'b0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_q        <= 1'b0;
      rd_vld_q    <= 1'b0;
      port_addr_q <= '0;
      exp_q       <= '0;
      elem_p_q    <= '0;
    end else begin
      wr_q        <= run && !cur_rd;
      rd_vld_q    <= run && cur_rd;
      port_addr_q <= run ? addr_q : '0;
      exp_q       <= run ? cur_data : '0;
      elem_p_q    <= run ? elem_q : '0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            bg_q    <= bg_sel;
            elem_q  <= E0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!elem_end) begin
            if (!last_op) begin
              op_q <= 1'b1;
            end else begin
              op_q   <= 1'b0;
              addr_q <= eop.down ? addr_q - 1'b1 : addr_q + 1'b1;
            end
          end else if (elem_q == E5) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
            op_q    <= 1'b0;
            addr_q  <= '0;
          end else begin
            elem_q <= elem_q + 3'd1;
            op_q   <= 1'b0;
            addr_q <= nxt_op.down ? CAP_A : '0;
          end
        end
        S_DRAIN: begin
          // Covers the port register plus the two-cycle read latency.
          if (drain_q == 2'd2) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign write_read = wr_q;
  assign address    = port_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

  mbist_resp_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_cmp (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr_i           (accept),
    .rd_vld_i        (rd_vld_q),
    .addr_i          (port_addr_q),
    .elem_i          (elem_p_q),
    .exp_i           (exp_q),
    .rdata_i         (rdata),
    .fail_o          (fail),
    .fail_count_o    (fail_count),
    .fail_addr_o     (fail_addr),
    .fail_elem_o     (fail_elem),
    .fail_syndrome_o (fail_syndrome)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench: behavioural memory with read-path stuck-at faults and a
// March C- reference model built from the element table.
module tb_mbist_march_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int CAP = 15;
  localparam int CW  = 8;
  localparam int N   = 10 * (CAP + 1);

  localparam int NOP = 0, W0 = 1, W1 = 2, R0 = 3, R1 = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, bg_sel;
  logic          write_read, busy, done, fail;
  logic [AW-1:0] address, fail_addr;
  logic [DW-1:0] wdata, rdata, fail_syndrome;
  logic [CW-1:0] fail_count;
  logic [2:0]    fail_elem;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bg_sel(bg_sel),
    .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .fail(fail), .fail_count(fail_count),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_syndrome(fail_syndrome)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- memory under test ----------------
  int            f_addr = -1;
  logic [DW-1:0] sa1 = '0, sa0 = '0;
  logic [DW-1:0] mem [0:CAP];
  logic [DW-1:0] wd_d, rd1;

  function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input int a);
    return (a == f_addr) ? ((v | sa1) & ~sa0) : v;
  endfunction

  always @(posedge clk) begin
    wd_d <= wdata;
    if (write_read) mem[address] <= wd_d;
    rd1   <= rd_fault(mem[address], int'(address));
    rdata <= rd1;
  end

  // ---------------- reference model ----------------
  typedef struct { bit wr; int a; logic [DW-1:0] d; } op_t;
  op_t ops[$];
  int  el_op [6][2] = '{'{W0, NOP}, '{R0, W1}, '{R1, W0}, '{R0, W1}, '{R1, W0}, '{R0, NOP}};
  bit  el_dn [6]    = '{0, 0, 0, 1, 1, 0};
  int            x_cnt, x_addr, x_elem;
  logic [DW-1:0] x_syn;

  task automatic build_model(input bit bg);
    logic [DW-1:0] d0, d, v;
    logic [DW-1:0] m [0:CAP];
    int a, code;
    op_t o;
    d0 = bg ? '1 : '0;
    ops.delete();
    x_cnt = 0; x_addr = 0; x_elem = 0; x_syn = '0;
    for (int e = 0; e < 6; e++)
      for (int j = 0; j <= CAP; j++) begin
        a = el_dn[e] ? CAP - j : j;
        for (int i = 0; i < 2; i++) begin
          code = el_op[e][i];
          if (code != NOP) begin
            d    = (code == W1 || code == R1) ? ~d0 : d0;
            o.wr = (code == W0 || code == W1);
            o.a  = a;
            o.d  = d;
            ops.push_back(o);
            if (o.wr) m[a] = d;
            else begin
              v = rd_fault(m[a], a);
              if (v !== d) begin
                if (x_cnt == 0) begin x_addr = a; x_elem = e; x_syn = v ^ d; end
                if (x_cnt < 255) x_cnt++;
              end
            end
          end
        end
      end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr"}, write_read, 0);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_cnt"}, fail_count, 0);
    chk({tag, "_faddr"}, fail_addr, 0);
    chk({tag, "_felem"}, fail_elem, 0);
    chk({tag, "_fsyn"}, fail_syndrome, 0);
  endtask

  // One run; cycle t=0 is the first cycle with busy high.
  task automatic run(input bit bg, input int start_at, input int rst_at);
    logic [DW-1:0] ew;
    build_model(bg);
    @(negedge clk); start = 1'b1; bg_sel = bg;
    @(negedge clk); start = 1'b0; bg_sel = ~bg;
    for (int t = 0; t <= N + 3; t++) begin
      if (t == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin chk_idle("rst_mid"); @(negedge clk); end
        return;
      end
      chk("busy", busy, t <= N + 2);
      chk("done", done, t == N + 3);
      if (t >= 1 && t <= N) begin
        chk("wr", write_read, ops[t-1].wr);
        chk("addr", address, ops[t-1].a);
      end else begin
        chk("wr_idle", write_read, 0);
        chk("addr_idle", address, 0);
      end
      ew = '0;
      if (t < N) if (ops[t].wr) ew = ops[t].d;
      chk("wdata", wdata, ew);
      if (t == 0) begin
        chk("clr_fail", fail, 0);
        chk("clr_cnt", fail_count, 0);
        chk("clr_faddr", fail_addr, 0);
        chk("clr_syn", fail_syndrome, 0);
      end
      start = (t == start_at);
      if (t < N + 3) @(negedge clk);
    end
    start = 1'b0;
    chk("fail", fail, x_cnt != 0);
    chk("fail_count", fail_count, x_cnt);
    chk("fail_addr", fail_addr, x_addr);
    chk("fail_elem", fail_elem, x_elem);
    chk("fail_syndrome", fail_syndrome, x_syn);
    for (int a = 0; a <= CAP; a++) chk("mem_end", mem[a], bg ? 8'hFF : 8'h00);
    repeat (2) begin
      @(negedge clk);
      chk("done_hold", done, 1);
      chk("busy_idle", busy, 0);
      chk("wr_hold", write_read, 0);
      chk("cnt_hold", fail_count, x_cnt);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit bg;
    rst_n = 1'b0; start = 1'b0; bg_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    // fault-free, all-zeros background
    f_addr = -1; sa1 = '0; sa0 = '0;
    run(1'b0, -1, -1);
    chk("ff_cnt", fail_count, 0);

    // stuck-at-1 bit 1 @5, bg 0
    f_addr = 5; sa1 = 8'h02; sa0 = '0;
    run(1'b0, -1, -1);
    chk("sa1_cnt", fail_count, 3);
    chk("sa1_addr", fail_addr, 5);
    chk("sa1_elem", fail_elem, 1);
    chk("sa1_syn", fail_syndrome, 8'h02);

    // stuck-at-0 bit 7 @0, bg 0
    f_addr = 0; sa1 = '0; sa0 = 8'h80;
    run(1'b0, -1, -1);
    chk("sa0_cnt", fail_count, 2);
    chk("sa0_addr", fail_addr, 0);
    chk("sa0_elem", fail_elem, 2);
    chk("sa0_syn", fail_syndrome, 8'h80);

    // stuck-at-1 bit 1 @5, bg 1
    f_addr = 5; sa1 = 8'h02; sa0 = '0;
    run(1'b1, -1, -1);
    chk("bg1_cnt", fail_count, 2);
    chk("bg1_addr", fail_addr, 5);
    chk("bg1_elem", fail_elem, 2);
    chk("bg1_syn", fail_syndrome, 8'h02);

    // fault-free after faulty run, with a stray start mid-run
    f_addr = -1; sa1 = '0; sa0 = '0;
    run(1'b1, 40, -1);

    // reset in E2 while a miscompare for addr 6 is in flight
    f_addr = 6; sa1 = 8'h01; sa0 = 8'h80;
    run(1'b0, -1, 61);

    for (int r = 0; r < 6; r++) begin
      bg = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) begin
        f_addr = -1; sa1 = '0; sa0 = '0;
      end else begin
        f_addr = $urandom_range(CAP, 0);
        sa1    = DW'($urandom);
        sa0    = DW'($urandom) & ~sa1;
      end
      run(bg, ($urandom_range(2, 0) == 0) ? $urandom_range(N + 1, 1) : -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
